// File: rtl/pipelined_alu_if.sv
// Request/response bus of the pipelined ALU: request side (in_*) and
// result side (out_*), plus the synchronous flush. The producer/consumer
// drives the master modport; the ALU implements the slave modport.
interface pipelined_alu_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int OP_W   = 4    // must match alu_pkg::ALU_OP_WIDTH
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic              word;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output flush, in_valid, op, in1, in2, word, in_tag, out_ready,
        input  in_ready, out_valid, out, out_tag
    );

    modport slave (
        input  flush, in_valid, op, in1, in2, word, in_tag, out_ready,
        output in_ready, out_valid, out, out_tag
    );
endinterface

// File: rtl/pipelined_alu.sv
// Pipelined integer ALU: the result is computed combinationally from the
// request and then travels through STAGES valid/result/tag slots with an
// elastic valid/ready handshake on both sides.

package alu_pkg;
    localparam int ALU_OP_WIDTH = 4;

    // Team ALU op encoding; codes 8 and 9 are unassigned and yield 0.
    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SLL  = 4'd1,
        ALU_SEQ  = 4'd2,
        ALU_SNE  = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SRL  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_AND  = 4'd7,
        ALU_SUB  = 4'd10,
        ALU_SRA  = 4'd11,
        ALU_SLT  = 4'd12,
        ALU_SGE  = 4'd13,
        ALU_SLTU = 4'd14,
        ALU_SGEU = 4'd15
    } alu_op_e;
endpackage

module pipelined_alu #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 1
) (
    input  logic           clk,
    input  logic           reset,
    pipelined_alu_if.slave bus
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(DATA_W);

    if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
        $error("pipelined_alu: DATA_W must be 32 or 64");
    end
    if (!(STAGES == 1 || STAGES == 2)) begin : g_bad_stages
        $error("pipelined_alu: STAGES must be 1 or 2");
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  alu_res;
    logic [SHAMT_W-1:0] shamt;
    logic [31:0]        a32;
    logic [31:0]        b32;
    logic [4:0]         sh32;
    logic [31:0]        w_res;
    logic               word_mode;
    logic               word_op;

    // Full-width result, overridden by the sign-extended 32-bit result
    // for the ops that honour word mode.
    // NOTE: every signal written here gets a default first so that no path
    // through the case statements leaves it unassigned (which would infer a latch).
    always_comb begin
        alu_res   = '0;
        w_res     = '0;
        a32       = bus.in1[31:0];
        b32       = bus.in2[31:0];
        sh32      = bus.in2[4:0];
        shamt     = bus.in2[SHAMT_W-1:0];
        word_mode = (DATA_W == 64) && bus.word;
        word_op   = bus.op inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA};

        case (bus.op)
            ALU_ADD:  alu_res = bus.in1 + bus.in2;
            ALU_SUB:  alu_res = bus.in1 - bus.in2;
            ALU_XOR:  alu_res = bus.in1 ^ bus.in2;
            ALU_OR:   alu_res = bus.in1 | bus.in2;
            ALU_AND:  alu_res = bus.in1 & bus.in2;
            ALU_SLL:  alu_res = bus.in1 << shamt;
            ALU_SRL:  alu_res = bus.in1 >> shamt;
            ALU_SRA:  alu_res = DATA_W'($signed(bus.in1) >>> shamt);
            ALU_SEQ:  alu_res = DATA_W'(bus.in1 == bus.in2);
            ALU_SNE:  alu_res = DATA_W'(bus.in1 != bus.in2);
            ALU_SLT:  alu_res = DATA_W'($signed(bus.in1) <  $signed(bus.in2));
            ALU_SGE:  alu_res = DATA_W'($signed(bus.in1) >= $signed(bus.in2));
            ALU_SLTU: alu_res = DATA_W'(bus.in1 <  bus.in2);
            ALU_SGEU: alu_res = DATA_W'(bus.in1 >= bus.in2);
            default:  alu_res = '0;
        endcase

        case (bus.op)
            ALU_ADD: w_res = a32 + b32;
            ALU_SUB: w_res = a32 - b32;
            ALU_SLL: w_res = a32 << sh32;
            ALU_SRL: w_res = a32 >> sh32;
            ALU_SRA: w_res = $signed(a32) >>> sh32;
            default: w_res = '0;
        endcase

        if (word_mode && word_op) begin
            alu_res = DATA_W'(signed'(w_res));
        end
    end

    // ------------------------------------------------------------------
    // Elastic pipeline slots
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [DATA_W-1:0] res_q [STAGES];
    logic [DATA_W-1:0] res_d [STAGES];
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [TAG_W-1:0]  tag_d [STAGES];
    logic [STAGES:0]   ready;
    logic              accept;

    // Backpressure chain: a slot can load when empty or when it drains.
    always_comb begin
        ready[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready[k] = !v_q[k] || ready[k+1];
        end
        accept = bus.in_valid && ready[0] && !bus.flush;
    end

    // Next slot contents: shift forward where the downstream slot is ready;
    // data registers only load when a valid entry arrives, so a stalled
    // output holds its value.
    always_comb begin
        v_d   = v_q;
        res_d = res_q;
        tag_d = tag_q;

        if (ready[0]) begin
            v_d[0] = accept;
            if (accept) begin
                res_d[0] = alu_res;
                tag_d[0] = bus.in_tag;
            end
        end

        for (int k = 1; k < STAGES; k++) begin
            if (ready[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) begin
                    res_d[k] = res_q[k-1];
                    tag_d[k] = tag_q[k-1];
                end
            end
        end

        // A transfer on the flush cycle still completes at the consumer;
        // only the valid bits are dropped afterwards.
        if (bus.flush) begin
            v_d = '0;
        end
    end

    // Slot registers with synchronous reset taking priority over flush.
    // NOTE: non-blocking assignments here so every slot samples the pre-edge
    // value of its neighbour; blocking would let data ripple through in one edge.
    // NOTE: result/tag registers are reset too (not just valid bits) because
    // out and out_tag must read 0 after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q   <= '0;
            res_q <= '{default: '0};
            tag_q <= '{default: '0};
        end else begin
            v_q   <= v_d;
            res_q <= res_d;
            tag_q <= tag_d;
        end
    end

    assign bus.in_ready  = ready[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out       = res_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_alu.sv
// Self-checking bench for pipelined_alu. Three instances share one stimulus:
// A (32-bit, 1 stage), B (32-bit, 2 stages), C (64-bit, 2 stages).
module tb_pipelined_alu;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        word;
    logic        out_ready;
    logic [3:0]  op;
    logic [63:0] in1;
    logic [63:0] in2;
    logic [5:0]  in_tag;

    int n_checks = 0;
    int n_errors = 0;

    int dw_of [3] = '{32, 32, 64};
    int st_of [3] = '{1, 2, 2};

    pipelined_alu_if #(.DATA_W(32), .TAG_W(6)) if_a ();
    pipelined_alu_if #(.DATA_W(32), .TAG_W(6)) if_b ();
    pipelined_alu_if #(.DATA_W(64), .TAG_W(6)) if_c ();

    pipelined_alu #(.DATA_W(32), .TAG_W(6), .STAGES(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    pipelined_alu #(.DATA_W(32), .TAG_W(6), .STAGES(2)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
    pipelined_alu #(.DATA_W(64), .TAG_W(6), .STAGES(2)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

    assign if_a.flush = flush;     assign if_b.flush = flush;     assign if_c.flush = flush;
    assign if_a.in_valid = in_valid; assign if_b.in_valid = in_valid; assign if_c.in_valid = in_valid;
    assign if_a.op = op;           assign if_b.op = op;           assign if_c.op = op;
    assign if_a.in1 = in1[31:0];   assign if_b.in1 = in1[31:0];   assign if_c.in1 = in1;
    assign if_a.in2 = in2[31:0];   assign if_b.in2 = in2[31:0];   assign if_c.in2 = in2;
    assign if_a.word = word;       assign if_b.word = word;       assign if_c.word = word;
    assign if_a.in_tag = in_tag;   assign if_b.in_tag = in_tag;   assign if_c.in_tag = in_tag;
    assign if_a.out_ready = out_ready; assign if_b.out_ready = out_ready; assign if_c.out_ready = out_ready;

    function automatic logic [63:0] get_out(int w);
        case (w)
            0:       return 64'(if_a.out);
            1:       return 64'(if_b.out);
            default: return if_c.out;
        endcase
    endfunction

    function automatic logic [5:0] get_tag(int w);
        case (w)
            0:       return if_a.out_tag;
            1:       return if_b.out_tag;
            default: return if_c.out_tag;
        endcase
    endfunction

    function automatic logic get_valid(int w);
        case (w)
            0:       return if_a.out_valid;
            1:       return if_b.out_valid;
            default: return if_c.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(int w);
        case (w)
            0:       return if_a.in_ready;
            1:       return if_b.in_ready;
            default: return if_c.in_ready;
        endcase
    endfunction

    // Reference ALU: all arithmetic done on 64-bit values, then narrowed.
    function automatic logic [63:0] model(int dw, logic [3:0] op_i, logic [63:0] a_i,
                                          logic [63:0] b_i, logic word_i);
        logic [63:0] mask;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        longint      sa;
        longint      sb;
        int          sh;
        mask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (dw == 64 && word_i && (op_i inside {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA})) begin
            a  = a_i & 64'hFFFF_FFFF;
            b  = b_i & 64'hFFFF_FFFF;
            sa = longint'(int'(a_i[31:0]));
            sh = int'(b_i[4:0]);
            case (op_i)
                ALU_ADD: r = a + b;
                ALU_SUB: r = a - b;
                ALU_SLL: r = a << sh;
                ALU_SRL: r = a >> sh;
                default: r = 64'(sa >>> sh);
            endcase
            return {{32{r[31]}}, r[31:0]};
        end
        a = a_i & mask;
        b = b_i & mask;
        if (dw == 64) begin
            sa = $signed(a);
            sb = $signed(b);
            sh = int'(b[5:0]);
        end else begin
            sa = longint'(int'(a[31:0]));
            sb = longint'(int'(b[31:0]));
            sh = int'(b[4:0]);
        end
        case (op_i)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLL:  r = a << sh;
            ALU_SRL:  r = a >> sh;
            ALU_SRA:  r = 64'(sa >>> sh);
            ALU_SEQ:  r = (a == b)   ? 64'd1 : 64'd0;
            ALU_SNE:  r = (a != b)   ? 64'd1 : 64'd0;
            ALU_SLT:  r = (sa < sb)  ? 64'd1 : 64'd0;
            ALU_SGE:  r = (sa >= sb) ? 64'd1 : 64'd0;
            ALU_SLTU: r = (a < b)    ? 64'd1 : 64'd0;
            ALU_SGEU: r = (a >= b)   ? 64'd1 : 64'd0;
            default:  r = 64'd0;
        endcase
        return r & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = ALU_ADD;
        in1      = '0;
        in2      = '0;
        word     = 1'b0;
        in_tag   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic w, input logic [5:0] t);
        in_valid = 1'b1;
        op       = o;
        in1      = a;
        in2      = b;
        word     = w;
        in_tag   = t;
    endtask

    // ------------------------------------------------------------------
    // Directed single-op vectors
    // ------------------------------------------------------------------
    typedef struct {
        int          dut;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic        word;
        logic [5:0]  tag;
        logic [63:0] exp;
    } vec_t;

    task automatic run_vectors();
        vec_t vecs[$];
        vecs.push_back('{0, ALU_ADD,  64'hFFFF_FFFF, 64'h1, 1'b0, 6'd5, 64'h0});
        vecs.push_back('{0, ALU_SUB,  64'h0, 64'h1, 1'b0, 6'd1, 64'hFFFF_FFFF});
        vecs.push_back('{0, ALU_XOR,  64'hF0F0_F0F0, 64'hFF00_FF00, 1'b0, 6'd2, 64'h0FF0_0FF0});
        vecs.push_back('{0, ALU_OR,   64'h1234_0000, 64'h0000_5678, 1'b0, 6'd3, 64'h1234_5678});
        vecs.push_back('{0, ALU_AND,  64'hFFFF_0000, 64'h1234_5678, 1'b0, 6'd4, 64'h1234_0000});
        vecs.push_back('{0, ALU_SLL,  64'h1, 64'h21, 1'b0, 6'd6, 64'h2});
        vecs.push_back('{0, ALU_SRL,  64'h8000_0000, 64'd31, 1'b0, 6'd7, 64'h1});
        vecs.push_back('{0, ALU_SRA,  64'h8000_0000, 64'd4, 1'b0, 6'd8, 64'hF800_0000});
        vecs.push_back('{0, ALU_SEQ,  64'd5, 64'd5, 1'b0, 6'd9, 64'h1});
        vecs.push_back('{0, ALU_SNE,  64'd5, 64'd5, 1'b0, 6'd10, 64'h0});
        vecs.push_back('{0, ALU_SGE,  64'hFFFF_FFFF, 64'd1, 1'b0, 6'd11, 64'h0});
        vecs.push_back('{0, ALU_SGEU, 64'hFFFF_FFFF, 64'd1, 1'b0, 6'd12, 64'h1});
        vecs.push_back('{0, 4'd8,     64'h1234, 64'h5678, 1'b0, 6'd63, 64'h0});
        vecs.push_back('{0, ALU_ADD,  64'h7FFF_FFFF, 64'h1, 1'b1, 6'd13, 64'h8000_0000});
        vecs.push_back('{2, ALU_ADD,  64'h7FFF_FFFF, 64'h1, 1'b1, 6'd14, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{2, ALU_SRL,  64'hFFFF_FFFF_8000_0000, 64'd4, 1'b1, 6'd15, 64'h0000_0000_0800_0000});
        vecs.push_back('{2, ALU_SRL,  64'hFFFF_FFFF_8000_0000, 64'd4, 1'b0, 6'd16, 64'h0FFF_FFFF_F800_0000});
        vecs.push_back('{2, ALU_SRA,  64'h8000_0000, 64'd4, 1'b1, 6'd17, 64'hFFFF_FFFF_F800_0000});
        vecs.push_back('{2, ALU_SLL,  64'h1, 64'd31, 1'b1, 6'd18, 64'hFFFF_FFFF_8000_0000});
        vecs.push_back('{2, ALU_XOR,  64'h1_0000_0000, 64'h1, 1'b1, 6'd19, 64'h1_0000_0001});
        vecs.push_back('{2, ALU_SUB,  64'h0, 64'h1, 1'b1, 6'd20, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2, ALU_SLT,  64'h8000_0000_0000_0000, 64'h1, 1'b0, 6'd21, 64'h1});
        vecs.push_back('{2, ALU_SLL,  64'h1, 64'h7F, 1'b0, 6'd22, 64'h8000_0000_0000_0000});

        foreach (vecs[i]) begin
            automatic vec_t v   = vecs[i];
            automatic int   lat = 1;
            @(negedge clk);
            out_ready = 1'b1;
            drive(v.op, v.a, v.b, v.word, v.tag);
            #1;
            check($sformatf("vec%0d_in_ready", i), 64'(get_ready(v.dut)), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            while (!get_valid(v.dut) && lat < 6) begin
                @(negedge clk);
                #1;
                lat++;
            end
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(st_of[v.dut]));
            check($sformatf("vec%0d_out", i), get_out(v.dut), v.exp);
            check($sformatf("vec%0d_tag", i), 64'(get_tag(v.dut)), 64'(v.tag));
            repeat (3) @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    // Multi-cycle corner cases
    // ------------------------------------------------------------------
    task automatic seq_back_to_back();
        logic [3:0]  ops  [3] = '{ALU_SLT, ALU_SLTU, ALU_SRA};
        logic [63:0] as   [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h8000_0000};
        logic [63:0] bs   [3] = '{64'd1, 64'd1, 64'd4};
        logic [63:0] expv [3] = '{64'd1, 64'd0, 64'hF800_0000};
        logic        vld  [7];
        logic [63:0] o    [7];
        do_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c < 3) drive(ops[c], as[c], bs[c], 1'b0, 6'(c + 1));
            else       in_valid = 1'b0;
            #1;
            vld[c] = if_b.out_valid;
            o[c]   = 64'(if_b.out);
        end
        check("b2b_valid_c1", 64'(vld[1]), 64'd0);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_valid_c%0d", k + 2), 64'(vld[k+2]), 64'd1);
            check($sformatf("b2b_out_c%0d", k + 2), o[k+2], expv[k]);
        end
        check("b2b_valid_c5", 64'(vld[5]), 64'd0);
    endtask

    task automatic seq_backpressure();
        int          accepted = 0;
        logic [5:0]  got_tag [$];
        logic [63:0] got_out [$];
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(ALU_ADD, 64'(100 + c), 64'(c), 1'b0, 6'(10 + c));
            #1;
            if (if_b.in_ready) accepted++;
            if (c >= 2) begin
                check($sformatf("bp_in_ready_c%0d", c), 64'(if_b.in_ready), 64'd0);
                check($sformatf("bp_out_valid_c%0d", c), 64'(if_b.out_valid), 64'd1);
                check($sformatf("bp_out_stable_c%0d", c), 64'(if_b.out), 64'd100);
                check($sformatf("bp_tag_stable_c%0d", c), 64'(if_b.out_tag), 64'd10);
            end
        end
        check("bp_accepted", 64'(accepted), 64'd2);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (if_b.out_valid) begin
                got_tag.push_back(if_b.out_tag);
                got_out.push_back(64'(if_b.out));
            end
        end
        check("bp_drain_count", 64'(got_tag.size()), 64'd2);
        if (got_tag.size() == 2) begin
            check("bp_drain_tag0", 64'(got_tag[0]), 64'd10);
            check("bp_drain_out0", got_out[0], 64'd100);
            check("bp_drain_tag1", 64'(got_tag[1]), 64'd11);
            check("bp_drain_out1", got_out[1], 64'd102);
        end
    endtask

    task automatic seq_flush();
        int seen  = 0;
        int waitc = 0;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(ALU_ADD, 64'(c), 64'd1, 1'b0, 6'(20 + c));
            flush = (c == 2);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            flush     = 1'b0;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (if_b.out_valid) seen++;
        end
        check("flush_no_out_valid", 64'(seen), 64'd0);
        @(negedge clk);
        drive(ALU_ADD, 64'd5, 64'd6, 1'b0, 6'd42);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        while (!if_b.out_valid && waitc < 6) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        check("flush_next_valid", 64'(if_b.out_valid), 64'd1);
        check("flush_next_tag", 64'(if_b.out_tag), 64'd42);
        check("flush_next_out", 64'(if_b.out), 64'd11);
    endtask

    task automatic seq_flush_with_transfer();
        do_reset();
        @(negedge clk);
        drive(ALU_ADD, 64'd1, 64'd2, 1'b0, 6'd7);
        @(negedge clk);
        drive(ALU_ADD, 64'd9, 64'd9, 1'b0, 6'd8);
        flush = 1'b1;
        #1;
        check("flushxfer_valid", 64'(if_a.out_valid), 64'd1);
        check("flushxfer_tag", 64'(if_a.out_tag), 64'd7);
        check("flushxfer_out", 64'(if_a.out), 64'd3);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flushxfer_after_c1", 64'(if_a.out_valid), 64'd0);
        @(negedge clk);
        #1;
        check("flushxfer_after_c2", 64'(if_a.out_valid), 64'd0);
    endtask

    task automatic seq_reset_midstream();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            out_ready = 1'b0;
            drive(ALU_ADD, 64'd50, 64'(c), 1'b0, 6'(30 + c));
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstmid_full_valid", 64'(if_b.out_valid), 64'd1);
        check("rstmid_full_ready", 64'(if_b.in_ready), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rstmid_out_valid", 64'(if_b.out_valid), 64'd0);
        check("rstmid_in_ready", 64'(if_b.in_ready), 64'd1);
        check("rstmid_out", 64'(if_b.out), 64'd0);
        check("rstmid_tag", 64'(if_b.out_tag), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Random traffic against per-instance in-order scoreboards
    // ------------------------------------------------------------------
    task automatic random_test(input int n_cycles);
        logic [69:0] sb [3][4];
        int          hd [3] = '{0, 0, 0};
        int          cnt [3] = '{0, 0, 0};
        logic        stalled [3] = '{1'b0, 1'b0, 1'b0};
        logic [63:0] held_out [3];
        logic [5:0]  held_tag [3];
        logic [69:0] item;
        do_reset();
        for (int c = 0; c < n_cycles + 8; c++) begin
            @(negedge clk);
            if (c < n_cycles) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                flush     = ($urandom_range(0, 31) == 0);
                op        = 4'($urandom_range(0, 15));
                in1       = {$urandom(), $urandom()};
                in2       = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom(), $urandom()};
                if ($urandom_range(0, 7) == 0) in2 = in1;
                word      = 1'($urandom_range(0, 1));
                in_tag    = 6'($urandom());
            end else begin
                idle_inputs();
                out_ready = 1'b1;
            end
            #1;
            for (int w = 0; w < 3; w++) begin
                if (stalled[w]) begin
                    check($sformatf("rnd_d%0d_hold_valid", w), 64'(get_valid(w)), 64'd1);
                    check($sformatf("rnd_d%0d_hold_out", w), get_out(w), held_out[w]);
                    check($sformatf("rnd_d%0d_hold_tag", w), 64'(get_tag(w)), 64'(held_tag[w]));
                end
                if (get_valid(w) && out_ready) begin
                    if (cnt[w] == 0) begin
                        check($sformatf("rnd_d%0d_unexpected_out", w), 64'(get_valid(w)), 64'd0);
                    end else begin
                        item = sb[w][hd[w]];
                        hd[w] = (hd[w] + 1) % 4;
                        cnt[w]--;
                        check($sformatf("rnd_d%0d_out", w), get_out(w), item[63:0]);
                        check($sformatf("rnd_d%0d_tag", w), 64'(get_tag(w)), 64'(item[69:64]));
                    end
                end
                if (in_valid && get_ready(w) && !flush) begin
                    if (cnt[w] >= 4) begin
                        check($sformatf("rnd_d%0d_overaccept", w), 64'(get_ready(w)), 64'd0);
                    end else begin
                        sb[w][(hd[w] + cnt[w]) % 4] = {in_tag, model(dw_of[w], op, in1, in2, word)};
                        cnt[w]++;
                    end
                end
                if (flush) cnt[w] = 0;
                stalled[w]  = get_valid(w) && !out_ready && !flush;
                held_out[w] = get_out(w);
                held_tag[w] = get_tag(w);
            end
        end
        for (int w = 0; w < 3; w++) begin
            check($sformatf("rnd_d%0d_drained", w), 64'(cnt[w]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        idle_inputs();
        do_reset();
        #1;
        for (int w = 0; w < 3; w++) begin
            check($sformatf("reset_d%0d_out_valid", w), 64'(get_valid(w)), 64'd0);
            check($sformatf("reset_d%0d_out", w), get_out(w), 64'd0);
            check($sformatf("reset_d%0d_tag", w), 64'(get_tag(w)), 64'd0);
            check($sformatf("reset_d%0d_in_ready", w), 64'(get_ready(w)), 64'd1);
        end
        run_vectors();
        seq_back_to_back();
        seq_backpressure();
        seq_flush();
        seq_flush_with_transfer();
        seq_reset_midstream();
        random_test(3000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
